// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Shared definitions for the SPI initiator: frame width, bit counter width,
//   SPI mode and the frame sequencing state type.
//   No ports (package).
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int FRAME_BITS = 32;
  localparam int BITCNT_W   = $clog2(FRAME_BITS);
  localparam int SPI_MODE   = 0;  // CPOL=0, CPHA=0

  // Frame sequencing: select setup, bit shifting, select hold, inter-frame gap.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_sck_gen.sv
// -----------------------------------------------------------------------------
// spi_sck_gen
//   Serial clock phase generator. While en is high it produces a clock that
//   starts low and toggles every CLK_DIV clk cycles; while en is low the phase
//   counter and clock are held at zero, so no SCK activity can leak outside
//   the bit-shifting window.
// Ports
//   clk      in   system clock
//   reset    in   synchronous, active-high
//   en       in   run the phase counter (high only while shifting bits)
//   sck      out  registered serial clock level
//   rise_stb out  high in the cycle whose closing edge takes sck 0->1
//   fall_stb out  high in the cycle whose closing edge takes sck 1->0
// -----------------------------------------------------------------------------
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise_stb,
  output logic fall_stb
);

  logic [7:0] phase_q, phase_d;
  logic       sck_q, sck_d;
  logic       phase_end;

  assign phase_end = en && (phase_q == 8'(CLK_DIV - 1));

  always_comb begin
    phase_d = phase_q;
    sck_d   = sck_q;
    if (!en) begin
      phase_d = '0;
      sck_d   = 1'b0;
    end else if (phase_end) begin
      phase_d = '0;
      sck_d   = ~sck_q;
    end else begin
      phase_d = phase_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      sck_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sck_q   <= sck_d;
    end
  end

  // Strobes announce the edge that the register will make at the next clk edge.
  assign sck      = sck_q;
  assign rise_stb = phase_end && !sck_q;
  assign fall_stb = phase_end &&  sck_q;

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   SPI initiator for 32-bit frames, mode 0, MSB first, active-low select.
//   A word accepted on tx_valid/tx_ready is shifted out on MOSI while MISO is
//   captured; the received word is returned on rx_data with a one-cycle
//   rx_valid strobe at the end of the frame. Every SCK phase and select
//   interval is at least several clk long so a peer that oversamples SCK/SSEL
//   through a synchroniser sees clean edges.
// Build option
//   SPI_MASTER_RX_EN : when defined, MISO is synchronised and captured into
//                      rx_data. When undefined, MISO is ignored, rx_data stays
//                      0 and rx_valid is a pure end-of-frame strobe.
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-high
//   en        in   allow new frames to start (does not abort a frame)
//   tx_data   in   word to transmit, MSB first
//   tx_valid  in   tx_data valid
//   tx_ready  out  idle and enabled
//   rx_data   out  word received in the last completed frame
//   rx_valid  out  one-cycle pulse when rx_data is updated
//   busy      out  high from acceptance until the inter-frame gap ends
//   SCK       out  serial clock, idles low
//   MOSI      out  serial data out
//   SSEL      out  slave select, active low
//   MISO      in   serial data in (asynchronous to clk)
// -----------------------------------------------------------------------------
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  SCK,
  output logic                  MOSI,
  output logic                  SSEL,
  input  logic                  MISO
);

  spi_state_e            state_q, state_d;
  logic [7:0]            wait_q, wait_d;
  logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [FRAME_BITS-1:0] tx_shreg_q, tx_shreg_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  ssel_q, ssel_d;
  logic                  busy_q, busy_d;

  logic                  sck_rise, sck_fall;
  logic                  last_bit;
  logic                  ready_int;
  logic [FRAME_BITS-1:0] rx_word;

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (state_q == SHIFT),
    .sck      (SCK),
    .rise_stb (sck_rise),
    .fall_stb (sck_fall)
  );

  // The bit counter saturates on the final bit; leaving SHIFT is the done flag,
  // so the counter never wraps inside a frame.
  assign last_bit  = (bitcnt_q == BITCNT_W'(FRAME_BITS - 1));
  assign ready_int = (state_q == IDLE) && en && !reset;

`ifdef SPI_MASTER_RX_EN
  logic [1:0]            miso_sync_q, miso_sync_d;
  logic [FRAME_BITS-1:0] rx_shreg_q, rx_shreg_d;

  always_comb begin
    miso_sync_d = {miso_sync_q[0], MISO};
    rx_shreg_d  = rx_shreg_q;
    // Sample on the SCK rising edge; 32 shifts per frame overwrite the register.
    if (sck_rise) begin
      rx_shreg_d = {rx_shreg_q[FRAME_BITS-2:0], miso_sync_q[1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      miso_sync_q <= '0;
      rx_shreg_q  <= '0;
    end else begin
      miso_sync_q <= miso_sync_d;
      rx_shreg_q  <= rx_shreg_d;
    end
  end

  assign rx_word = rx_shreg_q;
`else
  logic unused_rx;
  assign unused_rx = MISO ^ sck_rise;
  assign rx_word   = '0;
`endif

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    bitcnt_d   = bitcnt_q;
    tx_shreg_d = tx_shreg_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tx_valid && ready_int) begin
          state_d    = SETUP;
          tx_shreg_d = tx_data;
          bitcnt_d   = '0;
          wait_d     = '0;
        end
      end
      SETUP: begin
        if (wait_q == 8'(CS_SETUP - 1)) begin
          state_d = SHIFT;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      SHIFT: begin
        // Zero fill: after the last shift the register is empty, so MOSI idles 0.
        if (sck_fall) begin
          tx_shreg_d = {tx_shreg_q[FRAME_BITS-2:0], 1'b0};
          if (last_bit) begin
            state_d = HOLD;
          end else begin
            bitcnt_d = bitcnt_q + BITCNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (wait_q == 8'(CS_HOLD - 1)) begin
          state_d    = GAP;
          wait_d     = '0;
          rx_data_d  = rx_word;
          rx_valid_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      GAP: begin
        if (wait_q == 8'(CS_IDLE - 1)) begin
          state_d = IDLE;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Select and busy are registered from the next state so they change
    // on the same edge as the state itself, glitch-free.
    ssel_d = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      bitcnt_q   <= '0;
      tx_shreg_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ssel_q     <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      bitcnt_q   <= bitcnt_d;
      tx_shreg_q <= tx_shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ssel_q     <= ssel_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_ready = ready_int;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign MOSI     = tx_shreg_q[FRAME_BITS-1];
  assign SSEL     = ssel_q;

endmodule
